// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit state encoding
package uart_pkg;

    // 50 MHz / 9600 baud; the receive path divides by the same constant
    localparam int BAUD_DIV_9600 = 5208;

    localparam int UART_DATA_BITS = 8;

    // Raw encodings, also used by status/debug readback elsewhere
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = TX_IDLE,
        S_START = TX_START,
        S_DATA  = TX_DATA,
        S_STOP  = TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with enable/clear and end-of-bit ticks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_9600
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int            CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(BAUD_DIV - 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count 0..BAUD_DIV-1 and wrap at bit end
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    // Counter register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tick marks the last cycle of a bit; pre_tick the cycle before, so the
    // owner can register an output that lines up with the last cycle
    assign tick_o     = en_i && (cnt_q == LAST);
    assign pre_tick_o = en_i && (cnt_q == PRE);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with busy and completion pulse
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = BAUD_DIV_9600,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       send,
    output logic       serialOut,
    output logic       busy,
    output logic       charSent
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  state_q;
    logic [7:0] shreg_q;
    logic [2:0] bit_idx_q;
    logic       serial_q;
    logic       busy_q;
    logic       char_sent_q;

    logic       baud_en;
    logic       baud_clr;
    logic       tick;
    logic       pre_tick;

    // The bit timer only runs while a frame is in flight and sits at zero in
    // IDLE, so every frame starts with a full-length start bit
    assign baud_en  = (state_q != S_IDLE);
    assign baud_clr = (state_q == S_IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .en_i       (baud_en),
        .clr_i      (baud_clr),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    // Frame FSM; every output is a flop so the TX line cannot glitch.
    // Outputs are loaded on the edge that enters each bit, which is why DATA
    // presents shreg_q[1] (the bit about to become shreg_q[0]) on a shift.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            serial_q    <= 1'b1;
            busy_q      <= 1'b0;
            char_sent_q <= 1'b0;
        end else begin
            char_sent_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    if (send) begin
                        shreg_q   <= DataIn;
                        bit_idx_q <= '0;
                        serial_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        serial_q <= shreg_q[0];
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg_q <= {1'b0, shreg_q[7:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_q <= '0;
                            serial_q  <= 1'b1;
                            state_q   <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= shreg_q[1];
                        end
                    end
                end
                S_STOP: begin
                    // Registered one cycle early so the pulse occupies the
                    // final stop-bit cycle exactly
                    if (pre_tick) begin
                        char_sent_q <= 1'b1;
                    end
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign serialOut = serial_q;
    assign busy      = busy_q;
    assign charSent  = char_sent_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BD  = 4;
    localparam int BD2 = BAUD_DIV_9600;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] DataIn   = 8'h00;
    logic       send     = 1'b0;
    logic       serialOut, busy, charSent;

    logic [7:0] data2 = 8'h00;
    logic       send2 = 1'b0;
    logic       serialOut2, busy2, charSent2;

    uart_tx #(.BAUD_DIV(BD)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .DataIn    (DataIn),
        .send      (send),
        .serialOut (serialOut),
        .busy      (busy),
        .charSent  (charSent)
    );

    uart_tx #(.BAUD_DIV(BD2)) dut_9600 (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .DataIn    (data2),
        .send      (send2),
        .serialOut (serialOut2),
        .busy      (busy2),
        .charSent  (charSent2)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int frames = 0;
    int exp_pulses = 0;
    int exp_frames = 0;

    logic [7:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Line receiver on the fast instance: samples mid-bit, pops the scoreboard
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [9:0] mon_bits = '0;
    logic [7:0] mon_exp;

    always @(negedge CLOCK_50) begin
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (charSent) pulses++;
            if (!mon_active && serialOut == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
            if (mon_active) begin
                if (mon_cnt % BD == BD / 2) mon_bits[mon_cnt / BD] = serialOut;
                if (mon_cnt == 10 * BD - 1) begin
                    mon_active = 1'b0;
                    frames++;
                    check("mon_start_bit", mon_bits[0], 1'b0);
                    check("mon_stop_bit", mon_bits[9], 1'b1);
                    check("sb_has_entry", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        mon_exp = sb_q.pop_front();
                        check("sb_data", mon_bits[8:1], mon_exp);
                    end
                end else begin
                    mon_cnt++;
                end
            end
        end
    end

    // Checks the 10*BD cycles following an acceptance edge; inj >= 0 pulses
    // a competing send with DataIn=3C at that cycle offset
    task automatic check_frame(input logic [9:0] line, input int inj, input string tag);
        for (int c = 0; c < 10 * BD; c++) begin
            check({tag, "_line"}, serialOut, line[c / BD]);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_charSent"}, charSent, (c == 10 * BD - 1));
            if (inj >= 0 && c == inj) begin
                send   = 1'b1;
                DataIn = 8'h3C;
            end else if (inj >= 0 && c == inj + 1) begin
                send = 1'b0;
            end
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_line"}, serialOut, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_charSent"}, charSent, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [9:0] line, input string tag);
        DataIn = d;
        send   = 1'b1;
        sb_q.push_back(d);
        step();
        send   = 1'b0;
        DataIn = ~d;
        check_frame(line, -1, tag);
        check_idle(tag);
        exp_pulses++;
        exp_frames++;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[0] is the first bit on the wire
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] rx2;
    logic [9:0] bits2;

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'h55, 10'b1010101010};
        vecs[3] = '{8'hBB, 10'b1101110110};
        vecs[4] = '{8'hFF, 10'b1111111110};
        vecs[5] = '{8'h3C, 10'b1001111000};

        // Reset held, then released with send low
        step();
        check("rst_line", serialOut, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_charSent", charSent, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("post_rst");
        end

        // Table: single frames, bit-exact per cycle plus scoreboard data
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].data, vecs[i].line, $sformatf("vec%0d", i));
            step();
        end

        // send held high: second frame accepted in the first IDLE cycle
        DataIn = 8'h00;
        send   = 1'b1;
        sb_q.push_back(8'h00);
        step();
        DataIn = 8'hFF;
        sb_q.push_back(8'hFF);
        check_frame(10'b1000000000, -1, "b2b_f1");
        check_idle("b2b_gap");
        step();
        send = 1'b0;
        check_frame(10'b1111111110, -1, "b2b_f2");
        check_idle("b2b_end");
        exp_pulses += 2;
        exp_frames += 2;

        // send during DATA is dropped; frame stays exact and nothing follows
        DataIn = 8'h81;
        send   = 1'b1;
        sb_q.push_back(8'h81);
        step();
        send   = 1'b0;
        check_frame(10'b1100000010, 14, "ignore");
        exp_pulses++;
        exp_frames++;
        for (int i = 0; i < 3 * BD; i++) begin
            check_idle("ignore_after");
            step();
        end
        check("ignore_pulse_count", pulses, exp_pulses);

        // Reset in bit 3 of 81 aborts the frame at once
        DataIn = 8'h81;
        send   = 1'b1;
        sb_q.push_back(8'h81);
        step();
        send = 1'b0;
        repeat (17) step();
        check("abort_pre_line", serialOut, 1'b0);
        check("abort_pre_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_line", serialOut, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_charSent", charSent, 1'b0);
        void'(sb_q.pop_back());
        step();
        step();
        reset = 1'b0;
        step();
        check_idle("abort_after");
        check("abort_pulse_count", pulses, exp_pulses);
        run_frame(8'h81, 10'b1100000010, "recover");

        // Full-rate instance: mid-bit receive of one byte at 9600 baud
        data2 = 8'hBB;
        send2 = 1'b1;
        step();
        send2 = 1'b0;
        data2 = 8'h00;
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? (BD2 / 2) : BD2) step();
            bits2[k] = serialOut2;
        end
        check("r9600_start", bits2[0], 1'b0);
        check("r9600_stop", bits2[9], 1'b1);
        rx2 = bits2[8:1];
        check("r9600_data", rx2, 8'hBB);
        repeat (BD2 / 2 - 1) step();
        check("r9600_charSent", charSent2, 1'b1);
        check("r9600_busy_last", busy2, 1'b1);
        step();
        check("r9600_busy_fall", busy2, 1'b0);
        check("r9600_charSent_off", charSent2, 1'b0);

        check("total_pulses", pulses, exp_pulses);
        check("total_frames", frames, exp_frames);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
